// File: rtl/keypad_encoder_pkg.sv
// Shared keypad constants and FSM encoding, reused by the encoder and the timer-load logic.
package keypad_encoder_pkg;

    localparam int NUM_KEYS  = 10;
    localparam int BCD_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_HOLD         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } kp_state_t;

endpackage

// File: rtl/keypad_encoder_onehot_to_bcd.sv
// Combinational key-line decode: lowest active index as BCD, plus one-hot and multi-key flags.
module key_onehot_to_bcd
    import keypad_encoder_pkg::*;
(
    input  logic [NUM_KEYS-1:0]  key,
    output logic [BCD_WIDTH-1:0] bcd,
    output logic                 one_hot,
    output logic                 multi
);

    logic [BCD_WIDTH-1:0] ones;

    // Descending scan leaves the lowest set index, so bcd never leaves 0..9.
    always_comb begin
        bcd  = '0;
        ones = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key[i]) begin
                bcd  = BCD_WIDTH'(i);
                ones = ones + BCD_WIDTH'(1);
            end
        end
    end

    assign one_hot = (ones == BCD_WIDTH'(1));
    assign multi   = (ones >  BCD_WIDTH'(1));

endmodule

// File: rtl/keypad_encoder.sv
// Debounced keypad-to-BCD encoder with a valid/ready handshake toward the timer loader.
module keypad_encoder #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int NUM_KEYS        = 10
) (
    input  logic                                    clock,
    input  logic                                    clear,
    input  logic [NUM_KEYS-1:0]                     keypad,
    input  logic                                    ready,
    output logic                                    valid,
    output logic [keypad_encoder_pkg::BCD_WIDTH-1:0] bcd_out,
    output logic                                    multi_key
);
    import keypad_encoder_pkg::*;

    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    kp_state_t             state;
    logic [CNT_W-1:0]      count;
    logic [NUM_KEYS-1:0]   sync_p0;
    logic [NUM_KEYS-1:0]   key_s;
    logic [NUM_KEYS-1:0]   key_q;

    logic [BCD_WIDTH-1:0]  key_bcd;
    logic                  key_one_hot;
    logic                  key_multi;

    key_onehot_to_bcd u_decode (
        .key     (key_s),
        .bcd     (key_bcd),
        .one_hot (key_one_hot),
        .multi   (key_multi)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            sync_p0   <= '0;
            key_s     <= '0;
            key_q     <= '0;
            count     <= '0;
            state     <= ST_IDLE;
            valid     <= 1'b0;
            bcd_out   <= '0;
            multi_key <= 1'b0;
        end else begin
            // Synchronizer boundary: only key_s feeds decisions below.
            sync_p0   <= keypad;
            key_s     <= sync_p0;
            multi_key <= key_multi;

            case (state)
                ST_IDLE: begin
                    if (key_one_hot) begin
                        key_q <= key_s;
                        count <= CNT_W'(1);
                        state <= ST_DEBOUNCE;
                    end else begin
                        count <= '0;
                    end
                end

                // key_s equals key_q on the accepting edge, so its decode is key_q's index.
                ST_DEBOUNCE: begin
                    if (key_s != key_q) begin
                        count <= '0;
                        state <= ST_IDLE;
                    end else if (count == CNT_MAX) begin
                        bcd_out <= key_bcd;
                        valid   <= 1'b1;
                        state   <= ST_HOLD;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end

                ST_HOLD: begin
                    if (valid && ready) begin
                        valid <= 1'b0;
                        count <= '0;
                        state <= ST_WAIT_RELEASE;
                    end
                end

                ST_WAIT_RELEASE: begin
                    if (key_s != '0) begin
                        count <= '0;
                    end else if (count == CNT_MAX) begin
                        count <= '0;
                        state <= ST_IDLE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end

                default: begin
                    count <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder (DEBOUNCE_CYCLES=4) with a transfer scoreboard.
module tb_keypad_encoder;

    localparam int DB = 4;
    localparam int LAT = DB + 3;

    logic       clock = 1'b0;
    logic       clear;
    logic [9:0] keypad;
    logic       ready;
    logic       valid;
    logic [3:0] bcd_out;
    logic       multi_key;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    keypad_encoder #(
        .DEBOUNCE_CYCLES (DB),
        .NUM_KEYS        (10)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .keypad    (keypad),
        .ready     (ready),
        .valid     (valid),
        .bcd_out   (bcd_out),
        .multi_key (multi_key)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted transfer must match the next expected code.
    always @(negedge clock) begin
        if (clear === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL xfer_unexpected: got bcd=%0d expected no transfer", bcd_out);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (bcd_out !== e) begin
                    bad++;
                    $display("FAIL xfer_bcd: got %0d expected %0d", bcd_out, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input int max_edges, output int n);
        n = 0;
        while (valid !== 1'b1 && n < max_edges) begin
            tick();
            n++;
        end
    endtask

    task automatic watch_no_valid(input int cycles, output int seen);
        seen = 0;
        repeat (cycles) begin
            tick();
            if (valid === 1'b1) seen++;
        end
    endtask

    function automatic logic [9:0] digit(input int d);
        logic [9:0] v;
        v = '0;
        v[d] = 1'b1;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        int ok;

        clear  = 1'b1;
        keypad = '0;
        ready  = 1'b0;
        #2 clear = 1'b0;
        repeat (3) tick();
        check("rst_valid", int'(valid), 0);
        check("rst_bcd", int'(bcd_out), 0);
        check("rst_multi", int'(multi_key), 0);
        clear = 1'b1;
        repeat (3) tick();

        // Clean press of digit 7, ready high throughout.
        ready = 1'b1;
        exp_q.push_back(4'd7);
        keypad = digit(7);
        wait_valid(30, n);
        check("clean_latency", n, LAT);
        check("clean_bcd", int'(bcd_out), 7);
        tick();
        check("clean_one_cycle", int'(valid), 0);
        watch_no_valid(15, seen);
        check("clean_no_repeat", seen, 0);
        keypad = '0;
        repeat (12) tick();

        // Bouncing digit 3, then held.
        exp_q.push_back(4'd3);
        seen = 0;
        repeat (3) begin
            keypad = digit(3);
            repeat (2) begin tick(); if (valid === 1'b1) seen++; end
            keypad = '0;
            tick();
            if (valid === 1'b1) seen++;
        end
        check("bounce_no_valid", seen, 0);
        keypad = digit(3);
        wait_valid(30, n);
        check("bounce_latency", n, LAT);
        tick();
        keypad = '0;
        repeat (12) tick();

        // Backpressure on digit 5, key released while waiting.
        ready = 1'b0;
        exp_q.push_back(4'd5);
        keypad = digit(5);
        wait_valid(30, n);
        check("bp_latency", n, LAT);
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) keypad = '0;
            tick();
            if (valid !== 1'b1 || bcd_out !== 4'd5) ok = 0;
        end
        check("bp_hold_stable", ok, 1);
        ready = 1'b1;
        tick();
        check("bp_xfer_clears", int'(valid), 0);
        repeat (12) tick();

        // Digits 2 and 9 together, then 9 released.
        keypad = digit(2) | digit(9);
        repeat (2) tick();
        check("multi_edge2", int'(multi_key), 0);
        tick();
        check("multi_edge3", int'(multi_key), 1);
        watch_no_valid(12, seen);
        check("multi_no_valid", seen, 0);
        exp_q.push_back(4'd2);
        keypad = digit(2);
        wait_valid(30, n);
        check("multi_single_latency", n, LAT);
        check("multi_cleared", int'(multi_key), 0);
        tick();
        keypad = '0;
        repeat (12) tick();

        // Clear during HOLD aborts without a transfer.
        ready = 1'b0;
        keypad = digit(4);
        wait_valid(30, n);
        check("rsthold_latency", n, LAT);
        check("rsthold_bcd", int'(bcd_out), 4);
        clear = 1'b0;
        #1;
        check("rsthold_async_valid", int'(valid), 0);
        check("rsthold_async_bcd", int'(bcd_out), 0);
        tick();
        clear = 1'b1;
        wait_valid(30, n);
        check("rsthold_relatency", n, LAT);
        exp_q.push_back(4'd4);
        ready = 1'b1;
        tick();
        check("rsthold_xfer_clears", int'(valid), 0);
        keypad = '0;
        repeat (12) tick();

        // Release glitch, then a press too soon is ignored.
        exp_q.push_back(4'd6);
        keypad = digit(6);
        wait_valid(30, n);
        check("rel_latency", n, LAT);
        tick();
        keypad = '0;
        tick();
        keypad = digit(6);
        tick();
        keypad = '0;
        repeat (3) tick();
        keypad = digit(1);
        watch_no_valid(20, seen);
        check("rel_early_press_ignored", seen, 0);
        keypad = '0;
        repeat (12) tick();
        exp_q.push_back(4'd1);
        keypad = digit(1);
        wait_valid(30, n);
        check("rel_next_latency", n, LAT);
        tick();
        keypad = '0;
        repeat (12) tick();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20, is the number of consecutive stable sampled cycles needed to accept a press or a release.
REQ-002 Parameter NUM_KEYS, default 10, is the number of keypad lines (digits 0..9); fixed at 10 for this revision.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 clear  input  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-005 keypad  input  10  raw, bouncy, asynchronous key lines, active-high; bit i is digit i.
REQ-006 ready  input  1  downstream timer loader accepts the code this cycle.
REQ-007 valid  output  1  bcd_out holds an accepted key code.
REQ-008 bcd_out  output  4  BCD digit 0..9 of the accepted key.
REQ-009 multi_key  output  1  registered flag: more than one synchronized key line is high.

Function
REQ-010 keypad SHALL pass through a 2-flop synchronizer; the second-stage value is key_s, and all decisions use only key_s.
REQ-011 FSM states SHALL be IDLE, DEBOUNCE, HOLD, WAIT_RELEASE.
REQ-012 IDLE: if key_s is exactly one-hot, capture it into key_q, set count=1, and go to DEBOUNCE; otherwise stay in IDLE with count=0.
REQ-013 DEBOUNCE: if key_s != key_q, go to IDLE with count=0 (bounce rejected); otherwise increment count.
REQ-014 DEBOUNCE: on the edge where count==DEBOUNCE_CYCLES and key_s==key_q, go to HOLD, load bcd_out with the index of key_q, and set valid=1.
REQ-015 Latency: for a clean press held steady, valid SHALL rise on the DEBOUNCE_CYCLES+3rd rising edge after the keypad change.
REQ-016 HOLD: valid and bcd_out SHALL stay stable until the edge with valid&&ready; on that edge, clear valid and go to WAIT_RELEASE with count=0.
REQ-017 HOLD: releasing the key or pressing extra keys SHALL NOT retract or alter valid or bcd_out.
REQ-018 ready asserted while valid=0 SHALL have no effect.
REQ-019 WAIT_RELEASE: count consecutive cycles with key_s==0; any nonzero key_s resets count to 0; at count==DEBOUNCE_CYCLES go to IDLE.
REQ-020 Each physical press SHALL produce exactly one valid/ready transfer; there is no auto-repeat.
REQ-021 multi_key SHALL equal (popcount(key_s)>1), registered one cycle later, in every state.
REQ-022 The counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL saturate, never wrap.
REQ-023 The FSM SHALL NOT use key index values 10..15; bcd_out SHALL only ever hold 0..9.

Reset
REQ-024 While clear=0: state=IDLE, count=0, key_q=0, both synchronizer stages=0, valid=0, bcd_out=4'd0, multi_key=0.
REQ-025 clear asserted mid-operation (any state, including HOLD with valid=1) SHALL abort immediately, with no transfer.
REQ-026 After clear deasserts, a key already held SHALL be treated as a new press, with full synchronizer and debounce latency.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (2-bit), BCD_WIDTH=4, and the NUM_KEYS constant for reuse by the timer-load logic.
REQ-028 The one-hot-to-BCD conversion and the popcount>1 detection SHALL live in one combinational sub-module, key_onehot_to_bcd.
REQ-029 The 2-flop synchronizer SHALL be inline, not a separate module.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Clean press: keypad=10'b00_1000_0000 (digit 7) held, ready=1 -> valid high for exactly 1 cycle on edge 7 after press, bcd_out=4'd7, then no further valid while held.
REQ-031 Bounce: digit 3 toggled with high for 2 cycles, low for 1, repeated 3 times, then held -> no valid during bouncing; one valid with bcd_out=3, DEBOUNCE_CYCLES+3 edges after the final stable rise.
REQ-032 Backpressure: digit 5 pressed with ready=0 for 10 cycles, key released at cycle 8, then ready=1 -> valid=1 and bcd_out=5 held throughout; transfer on the first ready edge.
REQ-033 Multi-key: digits 2 and 9 pressed together -> multi_key=1 after 3 edges, valid never rises; releasing digit 9 -> digit 2 accepted after debounce.
REQ-034 Reset mid-HOLD: valid=1 with bcd_out=4, then clear=0 for 1 cycle -> valid=0 and bcd_out=0 asynchronously; with digit 4 still held, valid returns after DEBOUNCE_CYCLES+3 edges.
REQ-035 Release bounce: after a transfer, the key released with a 1-cycle glitch high at release cycle 2 -> the next press is not accepted until 4 consecutive zero samples are seen.
